vend_change_dispenser: RTL and testbench

Change-payout stage directly downstream of the vending FSM. Accepts a change amount (in 5-cent units) over a valid/ready handshake and drives the three coin-hopper solenoids (quarter, dime, nickel) with timed pulses. Uses greedy selection, skipping empty hoppers. Reports completion and any unpaid shortfall to the FSM.

---
 rtl/vend_change_dispenser.sv | 157 +++++++++++++++
 tb/tb_vend_change_dispenser.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_dispenser.sv
// Change-payout stage: takes a change amount in 5-cent units and drives the
// quarter/dime/nickel hopper solenoids with timed pulses, greedy largest coin
// first, skipping empty hoppers. Reports completion and any unpaid shortfall.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only while IDLE; the requester must hold req_valid and
// req_amount stable until that edge. req_valid while busy is ignored.
module vend_change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [7:0] req_amount,
  output logic       req_ready,
  input  logic       empty_q,
  input  logic       empty_d,
  input  logic       empty_n,
  output logic       coin_q,
  output logic       coin_d,
  output logic       coin_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] shortfall,
  output logic [2:0] dbg_state
);

  // IDLE is encoding 0 so the debug port reads 0 out of reset.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_Q = 2'd0;
  localparam logic [1:0] SEL_D = 2'd1;
  localparam logic [1:0] SEL_N = 2'd2;

  localparam logic [7:0] VAL_Q = 8'd5;
  localparam logic [7:0] VAL_D = 8'd2;
  localparam logic [7:0] VAL_N = 8'd1;

  // Timer counts down to 0, so load one less than the wanted length.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] remaining, remaining_n;
  logic [1:0] coin_sel, coin_sel_n;
  logic [7:0] timer, timer_n;
  logic [7:0] shortfall_n;

  // State and datapath registers; reset drops everything back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 8'd0;
      coin_sel  <= SEL_Q;
      timer     <= 8'd0;
      shortfall <= 8'd0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      coin_sel  <= coin_sel_n;
      timer     <= timer_n;
      shortfall <= shortfall_n;
    end
  end

  // Next-state logic: greedy coin choice in SELECT, shared timer for PULSE/GAP.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    coin_sel_n  = coin_sel;
    timer_n     = timer;
    shortfall_n = shortfall;
    case (state)
      IDLE: begin
        if (req_valid) begin
          remaining_n = req_amount;
          shortfall_n = 8'd0;
          state_n     = SELECT;
        end
      end
      SELECT: begin
        // Value check comes before the subtract, so remaining never underflows.
        if (!empty_q && (remaining >= VAL_Q)) begin
          coin_sel_n  = SEL_Q;
          remaining_n = remaining - VAL_Q;
          timer_n     = PULSE_LOAD;
          state_n     = PULSE;
        end else if (!empty_d && (remaining >= VAL_D)) begin
          coin_sel_n  = SEL_D;
          remaining_n = remaining - VAL_D;
          timer_n     = PULSE_LOAD;
          state_n     = PULSE;
        end else if (!empty_n && (remaining >= VAL_N)) begin
          coin_sel_n  = SEL_N;
          remaining_n = remaining - VAL_N;
          timer_n     = PULSE_LOAD;
          state_n     = PULSE;
        end else begin
          // Zero when fully paid, otherwise the unpaid amount.
          shortfall_n = remaining;
          state_n     = DONE;
        end
      end
      PULSE: begin
        if (timer == 8'd0) begin
          timer_n = GAP_LOAD;
          state_n = GAP;
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      GAP: begin
        if (timer == 8'd0) begin
          state_n = SELECT;
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Solenoid drives registered from the next state, so they are high exactly
  // while PULSE is held and glitch-free; only one coin_sel is ever active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coin_q <= 1'b0;
      coin_d <= 1'b0;
      coin_n <= 1'b0;
    end else begin
      coin_q <= (state_n == PULSE) && (coin_sel_n == SEL_Q);
      coin_d <= (state_n == PULSE) && (coin_sel_n == SEL_D);
      coin_n <= (state_n == PULSE) && (coin_sel_n == SEL_N);
    end
  end

  // Status decodes straight off the state register.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: behavioural timeline model, per-cycle
// output compare, directed scenarios with literal expectations, random payouts.
module tb_vend_change_dispenser;

  localparam int P = 4;
  localparam int G = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_amount = 8'd0;
  logic       req_ready;
  logic       empty_q = 1'b0;
  logic       empty_d = 1'b0;
  logic       empty_n = 1'b0;
  logic       coin_q, coin_d, coin_n;
  logic       busy, done;
  logic [7:0] shortfall;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  vend_change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .empty_q(empty_q), .empty_d(empty_d), .empty_n(empty_n),
    .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
    .busy(busy), .done(done), .shortfall(shortfall), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit flip_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot is what the outputs must look like for one cycle. A payout is a
  // timeline: a selection cycle, then per coin P pulse cycles, G quiet cycles
  // and another selection, ending in a one-cycle done slot.
  typedef struct {
    bit sel;
    bit busy;
    bit done;
    int coin;   // 0 none, 1 quarter, 2 dime, 3 nickel
  } slot_t;

  slot_t plan_q[$];
  slot_t cur = '{1'b0, 1'b0, 1'b0, 0};
  int    m_rem = 0;
  int    m_short = 0;
  int    coin_val[3] = '{5, 2, 1};

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      plan_q.delete();
      cur     = '{1'b0, 1'b0, 1'b0, 0};
      m_rem   = 0;
      m_short = 0;
    end else if (cur.sel) begin
      bit emp[3];
      int pick;
      emp  = '{empty_q, empty_d, empty_n};
      pick = 0;
      for (int i = 0; i < 3; i++)
        if (pick == 0 && !emp[i] && coin_val[i] <= m_rem) pick = i + 1;
      if (pick != 0) begin
        m_rem -= coin_val[pick-1];
        repeat (P) plan_q.push_back('{1'b0, 1'b1, 1'b0, pick});
        repeat (G) plan_q.push_back('{1'b0, 1'b1, 1'b0, 0});
        plan_q.push_back('{1'b1, 1'b1, 1'b0, 0});
      end else begin
        m_short = m_rem;
        plan_q.push_back('{1'b0, 1'b1, 1'b1, 0});
      end
      cur = plan_q.pop_front();
    end else if (plan_q.size() > 0) begin
      cur = plan_q.pop_front();
    end else if (!cur.busy && req_valid) begin
      m_rem   = int'(req_amount);
      m_short = 0;
      cur     = '{1'b1, 1'b1, 1'b0, 0};
    end else begin
      cur = '{1'b0, 1'b0, 1'b0, 0};
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [12:0] exp_q[$];
  initial forever begin
    logic [12:0] exp_v, act_v;
    @(negedge clk);
    if (chk_en) begin
      exp_v = {~cur.busy, cur.busy, cur.done, cur.coin == 1, cur.coin == 2,
               cur.coin == 3, 8'(m_short)};
      exp_q.push_back(exp_v);
      act_v = {req_ready, busy, done, coin_q, coin_d, coin_n, shortfall};
      check("cycle_outputs", 32'(act_v), 32'(exp_q.pop_front()));
    end
  end

  // Random hopper run-outs/refills during the random phase.
  initial forever begin
    @(negedge clk);
    if (flip_en && $urandom_range(0, 15) == 0) begin
      empty_q = ($urandom_range(0, 3) == 0);
      empty_d = ($urandom_range(0, 3) == 0);
      empty_n = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int w = 0;
    while (!req_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check(name, 32'(req_ready), 32'd1);
  endtask

  // Sends one request and tracks the payout: cycle k is the state after
  // handshake edge + k. Coin rises are folded into seq (base 4, q=1 d=2 n=3).
  task automatic run_one(input logic [7:0] amt, input int exp_done, input int exp_seq,
                         input int exp_hi, input logic [7:0] exp_short,
                         input int empty_d_at, input bit toggle);
    int k, seq, hi, done_k;
    logic [2:0] prev, now;
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = amt;
    wait_ready("hs_ready");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0; seq = 0; hi = 0; done_k = -1; prev = 3'b000;
    while (k < 400) begin
      now = {coin_q, coin_d, coin_n};
      if (now[2] && !prev[2]) seq = seq * 4 + 1;
      if (now[1] && !prev[1]) seq = seq * 4 + 2;
      if (now[0] && !prev[0]) seq = seq * 4 + 3;
      hi += int'(coin_q) + int'(coin_d) + int'(coin_n);
      prev = now;
      if (done) begin
        done_k = k;
        check("shortfall_at_done", 32'(shortfall), 32'(exp_short));
        break;
      end
      if (k == empty_d_at) empty_d = 1'b1;
      if (toggle) begin
        req_valid  = k[0];
        req_amount = 8'd3;
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    check("done_cycle", 32'(done_k), 32'(exp_done));
    check("coin_sequence", 32'(seq), 32'(exp_seq));
    check("pulse_high_cycles", 32'(hi), 32'(exp_hi));
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("ready_after_done", 32'(req_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_shortfall", 32'(shortfall), 32'd0);
    check("rst_coins", 32'({coin_q, coin_d, coin_n}), 32'd0);
    check("rst_dbg_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Greedy: q, d, n.
    run_one(8'd8, 22, 27, 12, 8'd0, -1, 1'b0);
    // Quarter hopper empty: d, d, n.
    empty_q = 1'b1;
    run_one(8'd5, 22, 43, 12, 8'd0, -1, 1'b0);
    // All empty: immediate short.
    empty_d = 1'b1; empty_n = 1'b1;
    run_one(8'd7, 1, 0, 0, 8'd7, -1, 1'b0);
    // Quarter too big, dime and nickel empty.
    empty_q = 1'b0;
    run_one(8'd4, 1, 0, 0, 8'd4, -1, 1'b0);
    // Dime hopper runs out during the first dime pulse: d, n, n.
    empty_d = 1'b0; empty_n = 1'b0;
    run_one(8'd4, 22, 47, 12, 8'd0, 2, 1'b0);
    empty_d = 1'b0;
    // Request toggling while busy is ignored: q, n for amount 6.
    run_one(8'd6, 15, 7, 8, 8'd0, -1, 1'b1);
    // Zero amount.
    run_one(8'd0, 1, 0, 0, 8'd0, -1, 1'b0);

    // Reset in the 2nd cycle of a quarter pulse.
    @(negedge clk);
    req_valid = 1'b1; req_amount = 8'd5;
    wait_ready("rst_hs_ready");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_coin_q", 32'(coin_q), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_coin_q", 32'(coin_q), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_one(8'd1, 8, 3, 4, 8'd0, -1, 1'b0);

    // Random payouts, back-to-back requests, hoppers changing underneath.
    flip_en = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      req_valid  = 1'b1;
      req_amount = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 30));
      wait_ready("rand_hs_ready");
      if (!req_ready) break;
      @(posedge clk);
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    flip_en = 1'b0;
    wait_ready("final_idle");
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
